// File: rtl/lockin_demod.sv
// Dual-phase lock-in demodulator: one shared multiplier mixes each ADC sample with the
// DDS sin/cos pair, integrate-and-dump over 2^tc samples, X/Y out on a valid/ready handshake.
module lockin_demod #(
  parameter int DW    = 16,
  parameter int OW    = 32,
  parameter int TCW   = 4,
  parameter int MAXTC = 12
) (
  input  logic                 CLK36,
  input  logic                 rst,
  input  logic signed [DW-1:0] sample_i,
  input  logic                 sample_v,
  input  logic signed [DW-1:0] sin_i,
  input  logic signed [DW-1:0] cos_i,
  input  logic [TCW-1:0]       tc_i,
  input  logic                 clr_i,
  input  logic                 ready_i,
  output logic signed [OW-1:0] X_o,
  output logic signed [OW-1:0] Y_o,
  output logic                 valid_o,
  output logic                 overrun_o,
  output logic                 drop_o,
  output logic                 busy_o
);

  localparam int PW = 2 * DW;       // full-precision product
  localparam int AW = PW + MAXTC;   // accumulator: 2^MAXTC full-scale products cannot overflow
  localparam int CW = MAXTC + 1;    // sample counter must reach 2^MAXTC

  typedef enum logic [2:0] {
    IDLE,
    MUL_I,
    MUL_Q,
    ACC,
    DUMP
  } state_t;

  state_t state, state_nxt;

  logic signed [DW-1:0] smp_q, sin_q, cos_q;
  logic signed [PW-1:0] prod_q;
  logic signed [AW-1:0] acc_i, acc_q;
  logic [CW-1:0]        cnt;
  logic [TCW-1:0]       tc_lat;

  logic [CW-1:0]        cnt_inc;
  logic [CW-1:0]        win_len;
  logic                 win_done;
  logic signed [DW-1:0] mul_b;
  logic signed [PW-1:0] mul_p;
  logic signed [PW-1:0] fit_i, fit_q;
  logic                 set_ovr;
  logic                 set_drop;

  function automatic logic [TCW-1:0] clamp_tc(input logic [TCW-1:0] t);
    return (t > TCW'(MAXTC)) ? TCW'(MAXTC) : t;
  endfunction

  assign cnt_inc  = cnt + CW'(1);
  assign win_len  = CW'(1) << tc_lat;
  assign win_done = (cnt_inc == win_len);

  // The single multiplier sees sin in MUL_I and cos in MUL_Q.
  assign mul_b = (state == MUL_Q) ? cos_q : sin_q;
  assign mul_p = PW'(smp_q) * PW'(mul_b);

  // Averaged result always fits the product width; narrowing drops only sign copies.
  assign fit_i = PW'(acc_i >>> tc_lat);
  assign fit_q = PW'(acc_q >>> tc_lat);

  assign set_ovr  = (state == DUMP) && valid_o && !ready_i;
  assign set_drop = sample_v && (state != IDLE);
  assign busy_o   = (state != IDLE);

  // NOTE: every variable written in always_comb gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (sample_v) state_nxt = MUL_I;
      MUL_I:   state_nxt = MUL_Q;
      MUL_Q:   state_nxt = ACC;
      ACC:     state_nxt = win_done ? DUMP : IDLE;
      DUMP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge CLK36 or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge CLK36 or posedge rst) begin
    if (rst) begin
      smp_q  <= '0;
      sin_q  <= '0;
      cos_q  <= '0;
      prod_q <= '0;
      acc_i  <= '0;
      acc_q  <= '0;
      cnt    <= '0;
      tc_lat <= clamp_tc(tc_i);
      X_o    <= '0;
      Y_o    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (sample_v) begin
            smp_q <= sample_i;
            sin_q <= sin_i;
            cos_q <= cos_i;
          end
        end
        MUL_I: begin
          prod_q <= mul_p;
        end
        MUL_Q: begin
          acc_i  <= acc_i + AW'(prod_q);
          prod_q <= mul_p;
        end
        ACC: begin
          acc_q <= acc_q + AW'(prod_q);
          cnt   <= cnt_inc;
        end
        DUMP: begin
          X_o    <= OW'(fit_i);
          Y_o    <= OW'(fit_q);
          acc_i  <= '0;
          acc_q  <= '0;
          cnt    <= '0;
          tc_lat <= clamp_tc(tc_i);
        end
        default: ;
      endcase
    end
  end

  // A dump in the same cycle as a transfer keeps valid_o high with the fresh result.
  always_ff @(posedge CLK36 or posedge rst) begin
    if (rst) begin
      valid_o   <= 1'b0;
      overrun_o <= 1'b0;
      drop_o    <= 1'b0;
    end else begin
      if (state == DUMP) begin
        valid_o <= 1'b1;
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end

      if (set_ovr) begin
        overrun_o <= 1'b1;
      end else if (clr_i) begin
        overrun_o <= 1'b0;
      end

      if (set_drop) begin
        drop_o <= 1'b1;
      end else if (clr_i) begin
        drop_o <= 1'b0;
      end
    end
  end

endmodule
